// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Multi-lane test-pattern frame generator on a valid/ready stream. Emits
//   IMG_W x IMG_H pixels per frame, LANES pixels per beat (lane 0 = lowest x
//   in the LSBs), with sof/eol/eof markers and optional LINE_GAP idle cycles
//   after every eol transfer that is not eof.
//
//   Build option: define PSRC_FILE_EN to back mode 1 with an image memory.
//   Without it, no memory is built and mode 1 is the ramp of mode 0.
//
//   Ports
//     clk        clock, rising edge
//     reset      synchronous, active-high
//     start      pulse; begins a frame when idle
//     free_run   sampled at the eof transfer; 1 = next frame follows at once
//     mode       0 ramp, 1 file, 2 constant, 3 line bars (latched at frame start)
//     const_val  pixel value for mode 2 (latched at frame start)
//     ready      downstream accept
//     valid      beat available
//     data       LANES*PIXEL_W pixels
//     sof/eol/eof first beat of frame / last of line / last of frame
//     busy       frame in progress
//     frame_cnt  completed frames, wrapping

module psrc_lane #(
  parameter int PIXEL_W = 8
) (
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] ramp_px,
  input  logic [PIXEL_W-1:0] file_px,
  input  logic [PIXEL_W-1:0] const_px,
  input  logic [PIXEL_W-1:0] bar_px,
  output logic [PIXEL_W-1:0] pix
);
  always_comb begin
    case (mode)
      2'd0:    pix = ramp_px;
      2'd1:    pix = file_px;
      2'd2:    pix = const_px;
      default: pix = bar_px;
    endcase
  end
endmodule

module pixel_stream_source #(
  parameter int    PIXEL_W  = 8,
  parameter int    LANES    = 1,
  parameter int    IMG_W    = 32,
  parameter int    IMG_H    = 32,
  parameter int    LINE_GAP = 0,
  parameter string HEX_FILE = "image.hex"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       free_run,
  input  logic [1:0]                 mode,
  input  logic [PIXEL_W-1:0]         const_val,
  input  logic                       ready,
  output logic                       valid,
  output logic [LANES*PIXEL_W-1:0]   data,
  output logic                       sof,
  output logic                       eol,
  output logic                       eof,
  output logic                       busy,
  output logic [15:0]                frame_cnt
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW   = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         state;
  logic [XW-1:0]      x;        // x of the beat currently presented
  logic [YW-1:0]      y;
  logic [GW-1:0]      gap_cnt;
  logic [1:0]         mode_q;
  logic [PIXEL_W-1:0] cval_q;

  // Next-beat load: position/pattern of the beat to register into the
  // output stage. Outputs only change on a load, which keeps data/markers
  // stable while the sink stalls.
  logic               ld_en;
  logic [XW-1:0]      ld_x;
  logic [YW-1:0]      ld_y;
  logic [1:0]         ld_mode;
  logic [PIXEL_W-1:0] ld_cval;
  logic               ld_sof, ld_eol, ld_eof;
  logic               last_x, last_y, gap_done;
  logic [LANES-1:0][PIXEL_W-1:0] beat_pix;

  assign last_x   = (int'(x) == IMG_W - LANES);
  assign last_y   = (int'(y) == IMG_H - 1);
  assign gap_done = (state == S_GAP) && (int'(gap_cnt) == LINE_GAP - 1);

  always_comb begin
    ld_en   = 1'b0;
    ld_x    = x + XW'(LANES);
    ld_y    = y;
    ld_mode = mode_q;
    ld_cval = cval_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld_en   = 1'b1;
          ld_x    = '0;
          ld_y    = '0;
          ld_mode = mode;
          ld_cval = const_val;
        end
      end
      S_RUN: begin
        if (ready) begin
          if (last_x && last_y) begin
            // back-to-back frame: re-latch pattern, no gap
            ld_en   = free_run;
            ld_x    = '0;
            ld_y    = '0;
            ld_mode = mode;
            ld_cval = const_val;
          end else if (last_x) begin
            ld_en = (LINE_GAP == 0);
            ld_x  = '0;
            ld_y  = y + YW'(1);
          end else begin
            ld_en = 1'b1;
          end
        end
      end
      S_GAP: begin
        // x/y were already advanced at the eol transfer
        ld_en = gap_done;
        ld_x  = x;
        ld_y  = y;
      end
      default: ;
    endcase
  end

  assign ld_eol = (int'(ld_x) == IMG_W - LANES);
  assign ld_sof = (ld_x == '0) && (ld_y == '0);
  assign ld_eof = ld_eol && (int'(ld_y) == IMG_H - 1);

`ifdef PSRC_FILE_EN
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
  logic [PIXEL_W-1:0] mem [0:NPIX-1];
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PIXEL_W-1:0] ramp_px, file_px;
    assign ramp_px = PIXEL_W'(int'(ld_y) * IMG_W + int'(ld_x) + k);
`ifdef PSRC_FILE_EN
    assign file_px = mem[PW'(int'(ld_y) * IMG_W + int'(ld_x) + k)];
`else
    assign file_px = ramp_px;
`endif
    psrc_lane #(.PIXEL_W(PIXEL_W)) u_lane (
      .mode     (ld_mode),
      .ramp_px  (ramp_px),
      .file_px  (file_px),
      .const_px (ld_cval),
      .bar_px   (PIXEL_W'(ld_y)),
      .pix      (beat_pix[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      gap_cnt   <= '0;
      mode_q    <= '0;
      cval_q    <= '0;
      valid     <= 1'b0;
      data      <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (ld_en) begin
        x      <= ld_x;
        y      <= ld_y;
        mode_q <= ld_mode;
        cval_q <= ld_cval;
        data   <= beat_pix;
        sof    <= ld_sof;
        eol    <= ld_eol;
        eof    <= ld_eof;
        valid  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (ready) begin
            if (last_x && last_y) begin
              frame_cnt <= frame_cnt + 16'd1;
              if (!free_run) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                valid <= 1'b0;
                sof   <= 1'b0;
                eol   <= 1'b0;
                eof   <= 1'b0;
              end
            end else if (last_x && LINE_GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
              x       <= '0;
              y       <= y + YW'(1);
              valid   <= 1'b0;
              sof     <= 1'b0;
              eol     <= 1'b0;
              eof     <= 1'b0;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_done) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_stream_source.sv
module tb_pixel_stream_source;
  localparam int W = 32;
  localparam int H = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (1 lane, no gap)
  logic        rst_a, start_a, fr_a, rdy_a;
  logic [1:0]  mode_a;
  logic [7:0]  cv_a;
  logic        va, sofa, eola, eofa, busya;
  logic [7:0]  da;
  logic [15:0] fca;

  // DUT B: 4 lanes, 2-cycle line gap
  logic        rst_b, start_b, fr_b, rdy_b;
  logic [1:0]  mode_b;
  logic [7:0]  cv_b;
  logic        vb, sofb, eolb, eofb, busyb;
  logic [31:0] db;
  logic [15:0] fcb;

  pixel_stream_source dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .free_run(fr_a), .mode(mode_a),
    .const_val(cv_a), .ready(rdy_a), .valid(va), .data(da), .sof(sofa),
    .eol(eola), .eof(eofa), .busy(busya), .frame_cnt(fca)
  );

  pixel_stream_source #(.LANES(4), .LINE_GAP(2)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .free_run(fr_b), .mode(mode_b),
    .const_val(cv_b), .ready(rdy_b), .valid(vb), .data(db), .sof(sofb),
    .eol(eolb), .eof(eofb), .busy(busyb), .frame_cnt(fcb)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  f;   // {sof, eol, eof}
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;
  int total = 0, passed = 0;
  int beats_a = 0;
  int gap_b = 0, exp_gap_b = 0;
  bit gap_arm_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Expected beats of one frame (first nmax beats), built from the pixel formula.
  task automatic push(input bit to_b, input int lanes, input int md, input int cv, input int nmax);
    int n = 0;
    beat_t bt;
    for (int y = 0; y < H; y++) begin
      for (int xb = 0; xb < W; xb += lanes) begin
        if (n < nmax) begin
          bt.d = '0;
          for (int k = 0; k < lanes; k++) begin
            int px;
            px = (md == 2) ? cv : (md == 3) ? y : (y * W + xb + k);
            bt.d = bt.d | (32'(px & 255) << (8 * k));
          end
          bt.f = {(xb == 0 && y == 0), (xb == W - lanes), (xb == W - lanes && y == H - 1)};
          if (to_b) qb.push_back(bt);
          else qa.push_back(bt);
          n++;
        end
      end
    end
  endtask

  // Monitor A: pop on transfer, check hold while stalled
  always @(negedge clk) begin
    if (!rst_a) begin
      if (va && rdy_a) begin
        if (qa.size() == 0) chk("a_extra_beat", 32'd1, 32'd0);
        else begin
          ea = qa.pop_front();
          chk("a_data", 32'(da), ea.d);
          chk("a_flags", 32'({sofa, eola, eofa}), 32'(ea.f));
          beats_a++;
        end
      end else if (va && !rdy_a && qa.size() > 0) begin
        chk("a_hold_data", 32'(da), qa[0].d);
        chk("a_hold_flags", 32'({sofa, eola, eofa}), 32'(qa[0].f));
      end
    end
  end

  // Monitor B: pop on transfer, measure idle run after every eol
  always @(negedge clk) begin
    if (!rst_b) begin
      if (gap_arm_b) begin
        if (!vb) gap_b++;
        else begin
          chk("b_gap_len", 32'(gap_b), 32'(exp_gap_b));
          gap_arm_b = 0;
        end
      end
      if (vb && rdy_b) begin
        if (qb.size() == 0) chk("b_extra_beat", 32'd1, 32'd0);
        else begin
          eb = qb.pop_front();
          chk("b_data", db, eb.d);
          chk("b_flags", 32'({sofb, eolb, eofb}), 32'(eb.f));
        end
        if (eolb && (!eofb || fr_b)) begin
          gap_arm_b = 1;
          gap_b = 0;
          exp_gap_b = eofb ? 0 : 2;
        end
      end
    end
  end

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string nm);
    int n = 0;
    while (busya) begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin chk(nm, 32'd0, 32'd1); break; end
    end
  endtask

  task automatic wait_idle_b(input string nm);
    int n = 0;
    while (busyb) begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin chk(nm, 32'd0, 32'd1); break; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1; start_a = 0; fr_a = 0; rdy_a = 1; mode_a = 0; cv_a = 0;
    rst_b = 1; start_b = 0; fr_b = 0; rdy_b = 1; mode_b = 0; cv_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'({va, vb}), 32'd0);
    chk("rst_data_a", 32'(da), 32'd0);
    chk("rst_data_b", db, 32'd0);
    chk("rst_marks", 32'({sofa, eola, eofa, sofb, eolb, eofb}), 32'd0);
    chk("rst_busy", 32'({busya, busyb}), 32'd0);
    chk("rst_fcnt", {fca, fcb}, 32'd0);
    rst_a = 0; rst_b = 0;

    // B: free-running mode 3, two frames with line gaps
    push(1, 4, 3, 0, 1 << 30);
    push(1, 4, 3, 0, 1 << 30);
    mode_b = 3; fr_b = 1;
    pulse_b();
    for (int n = 0; n < 2000 && fcb < 16'd1; n++) begin @(posedge clk); #1; end
    fr_b = 0;
    wait_idle_b("b_freerun_timeout");
    @(negedge clk);
    chk("b_fcnt_2", 32'(fcb), 32'd2);
    chk("b_q_empty_1", 32'(qb.size()), 32'd0);

    // B: 4-lane ramp, first beat 0x03020100
    push(1, 4, 0, 0, 1 << 30);
    mode_b = 0;
    pulse_b();
    wait_idle_b("b_ramp_timeout");
    @(negedge clk);
    chk("b_fcnt_3", 32'(fcb), 32'd3);
    chk("b_q_empty_2", 32'(qb.size()), 32'd0);

    // A: ramp with 5-cycle stall on beat 10
    push(0, 1, 0, 0, 1 << 30);
    beats_a = 0;
    pulse_a();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (beats_a >= 10) break;
    end
    rdy_a = 0;
    repeat (5) @(posedge clk);
    #1 rdy_a = 1;
    wait_idle_a("a_ramp_timeout");
    @(negedge clk);
    chk("a_fcnt_1", 32'(fca), 32'd1);
    chk("a_busy_fall", 32'(busya), 32'd0);
    chk("a_q_empty_1", 32'(qa.size()), 32'd0);

    // A: constant, mode/value changed after start must not matter
    push(0, 1, 2, 8'hA5, 1 << 30);
    mode_a = 2; cv_a = 8'hA5;
    pulse_a();
    mode_a = 0; cv_a = 8'h00;
    wait_idle_a("a_const_timeout");
    @(negedge clk);
    chk("a_fcnt_2", 32'(fca), 32'd2);
    chk("a_q_empty_2", 32'(qa.size()), 32'd0);

    // A: mode 1 without the file build gives the ramp
    push(0, 1, 0, 0, 1 << 30);
    mode_a = 1;
    pulse_a();
    wait_idle_a("a_file_timeout");
    @(negedge clk);
    chk("a_fcnt_3", 32'(fca), 32'd3);
    chk("a_q_empty_3", 32'(qa.size()), 32'd0);

    // A: reset at beat 100 with start on the same edge
    push(0, 1, 0, 0, 100);
    mode_a = 0; beats_a = 0;
    pulse_a();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (beats_a >= 100) break;
    end
    rdy_a = 0; rst_a = 1; start_a = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(va), 32'd0);
    chk("mid_rst_busy", 32'(busya), 32'd0);
    chk("mid_rst_fcnt", 32'(fca), 32'd0);
    chk("mid_rst_data", 32'({da, sofa, eola, eofa}), 32'd0);
    chk("mid_rst_q_empty", 32'(qa.size()), 32'd0);
    rst_a = 0; start_a = 0; rdy_a = 1;

    // A: fresh frame after reset; a start mid-frame is ignored
    push(0, 1, 0, 0, 1 << 30);
    pulse_a();
    repeat (50) @(posedge clk);
    #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    wait_idle_a("a_post_rst_timeout");
    @(negedge clk);
    chk("a_fcnt_after_rst", 32'(fca), 32'd1);
    chk("a_q_empty_4", 32'(qa.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
